conv_pool: RTL and testbench
============================

# conv_pool

Downstream stage of the `conv` block. Consumes the serial 16-bit convolution result stream in row-major order and applies 2x2 max-pooling with stride 2, producing a serial pooled stream plus frame-level `busy`/`done` status. Output dimensions are floor(rows/2) x floor(cols/2); a trailing odd row or column is dropped. One line buffer holds the even row while the following odd row streams in.

## Interface
- `DW`, 16: data width of input and output samples (unsigned).
- `DIM_W`, 4: width of row/column count inputs.
- `MAX_COLS`, 15: line-buffer depth; largest supported `in_col`.

- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  frame start; latches `in_row`/`in_col` when idle.
- `in_row`  in  DIM_W  rows in the incoming frame.
- `in_col`  in  DIM_W  columns in the incoming frame (≤ `MAX_COLS`).
- `in_data`  in  DW  convolution result sample.
- `in_valid`  in  1  `in_data` is a valid sample this cycle.
- `out_data`  out  DW  pooled sample.
- `out_valid`  out  1  `out_data` valid; single-cycle per sample.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, state IDLE, row/col counters 0. Line buffer not cleared.
- States: IDLE, EVEN (store row into line buffer), ODD (pool against line buffer), DRAIN (discard trailing odd row), FIN.
- IDLE: `start`=1 latches dims, clears counters, `busy`=1. If `in_row`<2 or `in_col`<2 and product is 0 → FIN directly. Otherwise → EVEN.
- Counters advance only on `in_valid`=1; gaps in `in_valid` stall without effect. `in_valid` in IDLE/FIN is ignored.
- EVEN: `linebuf[col]` ← `in_data`. At last column → ODD if a row pair remains (row+1 < `in_row`), else DRAIN-equivalent handling (row is final, odd count) → FIN.
- ODD: even column: hold sample in `prev`. Odd column c: `out_data` ← max(`linebuf[c-1]`, `linebuf[c]`, `prev`, `in_data`), unsigned compare. Trailing odd column (c = `in_col`-1, `in_col` odd) consumed, no output. At last column → EVEN if ≥2 rows remain, → DRAIN if exactly 1 row remains, else FIN.
- DRAIN: consume `in_col` beats, no output, then FIN.
- Frames with `in_row`<2 or `in_col`<2 but nonzero size: all beats consumed, zero outputs.
- FIN: `done`=1 for one cycle, `busy`=0, → IDLE.
- `start` while `busy`=1 ignored. `in_col` > `MAX_COLS` is unsupported.
- Reset asserted mid-frame: next edge returns to reset values; partial frame discarded.

## Timing
- Output latency: `out_valid` asserts the cycle after the `in_valid` beat completing a 2x2 window.
- `done` asserts the cycle after the final input beat of the frame (`in_row`*`in_col` beats); for zero-size frames, the cycle after `start`.
- Next `start` accepted in the cycle after `done` (IDLE).
- Throughput: one input beat per cycle; no backpressure.

## Structure
- Shared package `conv_pkg`: `DW`, `DIM_W`, `MAX_COLS` constants; state enum typedef; `sample_t` typedef.
- One sub-module natural: `max4` (combinational unsigned 4-input max, DW-wide).
- Line buffer: register array, `MAX_COLS` x `DW`.

## Test plan
- 4x4 frame, `in_data` 1..16 row-major, continuous valid → outputs 6, 8, 14, 16; `done` one cycle after beat 16.
- 3x3 frame (nominal `conv` 5x5/3x3 output), data 1..9 → single output 5; beats 3, 6, 7–9 produce no output; `done` after beat 9.
- 4x4 frame 1..16 with `in_valid` toggled every other cycle → same outputs 6, 8, 14, 16, each one cycle after its completing beat.
- 2x2 frame {0xFFFF, 0, 0x8000, 0x7FFF} → output 0xFFFF (unsigned compare); 1x5 frame → no outputs, `done` after beat 5; 0x0 frame → `done` cycle after `start`.
- `rst_n`=0 after 6 beats of a 4x4 frame, then new 4x4 frame 16..1 → no stale outputs; outputs 16, 14, 8, 6.
- `start` pulsed mid-frame with different dims → ignored; original frame completes with correct outputs and single `done`.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the conv datapath and its 2x2 max-pool stage.
package conv_pkg;
  localparam int DW       = 16;
  localparam int DIM_W    = 4;
  localparam int MAX_COLS = 15;

  typedef logic [DW-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_DRAIN,
    S_FIN
  } state_t;
endpackage

// File: rtl/conv_pool_max4.sv
// Combinational unsigned maximum of four samples (one 2x2 pooling window).
module max4
  import conv_pkg::*;
(
  input  sample_t i_a,
  input  sample_t i_b,
  input  sample_t i_c,
  input  sample_t i_d,
  output sample_t o_y
);
  sample_t w_ab, w_cd;

  assign w_ab = (i_a > i_b) ? i_a : i_b;
  assign w_cd = (i_c > i_d) ? i_c : i_d;
  assign o_y  = (w_ab > w_cd) ? w_ab : w_cd;
endmodule

// File: rtl/conv_pool.sv
// 2x2 stride-2 max-pool over a row-major sample stream; even rows are parked
// in a line buffer and pooled as the following odd row streams in.
module conv_pool
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] in_row,
  input  logic [DIM_W-1:0] in_col,
  input  sample_t          in_data,
  input  logic             in_valid,
  output sample_t          out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  state_t           r_state, w_next;
  logic [DIM_W-1:0] r_rows, r_cols, r_row, r_col;
  sample_t          r_linebuf [MAX_COLS];
  sample_t          r_prev;
  sample_t          r_out_data;
  logic             r_out_valid, r_busy, r_done;

  logic             w_last_col, w_beat, w_fire;
  logic [DIM_W:0]   w_rows_left;
  sample_t          w_max;

  assign w_last_col  = (r_col == r_cols - DIM_W'(1));
  // Rows still to come after the current one.
  assign w_rows_left = {1'b0, r_rows} - {1'b0, r_row} - (DIM_W+1)'(1);
  assign w_beat      = in_valid && (r_state == S_EVEN || r_state == S_ODD || r_state == S_DRAIN);
  assign w_fire      = in_valid && (r_state == S_ODD) && r_col[0];

  // Even-column partner index is c with bit 0 cleared, i.e. c-1 for odd c.
  max4 u_max4 (
    .i_a (r_linebuf[{r_col[DIM_W-1:1], 1'b0}]),
    .i_b (r_linebuf[r_col]),
    .i_c (r_prev),
    .i_d (in_data),
    .o_y (w_max)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (start) begin
          if (in_row == '0 || in_col == '0)                    w_next = S_FIN;
          else if (in_row < DIM_W'(2) || in_col < DIM_W'(2))   w_next = S_DRAIN;
          else                                                 w_next = S_EVEN;
        end
      S_EVEN:
        if (in_valid && w_last_col)
          w_next = (w_rows_left != '0) ? S_ODD : S_FIN;
      S_ODD:
        if (in_valid && w_last_col) begin
          if (w_rows_left >= (DIM_W+1)'(2))      w_next = S_EVEN;
          else if (w_rows_left == (DIM_W+1)'(1)) w_next = S_DRAIN;
          else                                   w_next = S_FIN;
        end
      S_DRAIN:
        if (in_valid && w_last_col && w_rows_left == '0)
          w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rows      <= '0;
      r_cols      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_prev      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= w_fire;
      r_done      <= (w_next == S_FIN);
      r_busy      <= (w_next == S_EVEN || w_next == S_ODD || w_next == S_DRAIN);
      if (w_fire) r_out_data <= w_max;
      if (r_state == S_IDLE && start) begin
        r_rows <= in_row;
        r_cols <= in_col;
        r_row  <= '0;
        r_col  <= '0;
      end else if (w_beat) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end
      if (in_valid && r_state == S_ODD && !r_col[0]) r_prev <= in_data;
    end
  end

  // Line buffer carries no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (in_valid && r_state == S_EVEN) r_linebuf[r_col] <= in_data;
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule

// File: tb/tb_conv_pool.sv
// Bench for conv_pool: directed and random frames checked against a
// window-max reference model, including per-output and done timing.
module tb_conv_pool;
  import conv_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n, start, in_valid;
  logic [DIM_W-1:0] in_row, in_col;
  logic [DW-1:0]    in_data, out_data;
  logic             out_valid, busy, done;

  conv_pool dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_row(in_row), .in_col(in_col),
    .in_data(in_data), .in_valid(in_valid), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] frame [256];
  int            bcyc  [256];
  int            s_cyc, exp_done;
  bit            busy_mid;
  logic [DW-1:0] got_q[$], exp_q[$];
  int            got_cyc_q[$], exp_cyc_q[$], done_q[$];

  always @(negedge clk) begin
    if (out_valid) begin
      got_q.push_back(out_data);
      got_cyc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
  end

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reference: each output is the max of a full 2x2 window; it appears one
  // cycle after the beat that completes the window (bottom-right sample).
  function automatic void model(input int rows, input int cols);
    exp_q.delete();
    exp_cyc_q.delete();
    for (int r = 0; r < rows / 2; r++)
      for (int c = 0; c < cols / 2; c++) begin
        int tl = 2 * r * cols + 2 * c;
        int br = (2 * r + 1) * cols + 2 * c + 1;
        exp_q.push_back(mx(mx(frame[tl], frame[tl + 1]), mx(frame[br - 1], frame[br])));
        exp_cyc_q.push_back(bcyc[br] + 1);
      end
    exp_done = (rows * cols == 0) ? s_cyc + 1 : bcyc[rows * cols - 1] + 1;
  endfunction

  // gap: 0 continuous, 1 idle cycle between beats, 2 random idles.
  task automatic run_frame(input int rows, input int cols, input int gap, input bit mid_start);
    got_q.delete();
    got_cyc_q.delete();
    done_q.delete();
    @(negedge clk);
    start  = 1'b1;
    in_row = DIM_W'(rows);
    in_col = DIM_W'(cols);
    s_cyc  = cyc;
    @(negedge clk);
    start    = 1'b0;
    busy_mid = busy;
    for (int k = 0; k < rows * cols; k++) begin
      if ((gap == 1 && k > 0) || (gap == 2 && $urandom_range(3) == 0)) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frame[k];
      bcyc[k]  = cyc;
      if (mid_start && k == 5) begin
        start  = 1'b1;
        in_row = DIM_W'(2);
        in_col = DIM_W'(2);
      end
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    model(rows, cols);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_row = '0; in_col = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid, busy, done} !== 3'b000 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid/busy/done=%b data=%h want 000 0000", {out_valid, busy, done}, out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    // rows, cols, gap, mid_start, data mode (0 ramp 1..N, 1 unsigned corner, 2 random)
    int tbl [9][5] = '{'{4,4,0,0,0}, '{3,3,0,0,0}, '{4,4,1,0,0}, '{2,2,0,0,1}, '{1,5,0,0,0},
                       '{0,0,0,0,0}, '{4,4,0,1,0}, '{5,6,2,0,2}, '{15,15,0,0,2}};
    logic [DW-1:0] ramp_exp [4] = '{16'd6, 16'd8, 16'd14, 16'd16};
    for (int t = 0; t < 9; t++) begin
      for (int k = 0; k < 256; k++)
        frame[k] = (tbl[t][4] == 0) ? DW'(k + 1) : DW'($urandom);
      if (tbl[t][4] == 1) begin
        frame[0] = 16'hFFFF; frame[1] = 16'h0000; frame[2] = 16'h8000; frame[3] = 16'h7FFF;
      end
      run_frame(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3] != 0);
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL dir%0d_count: got %0d outputs want %0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
          n_fail++;
          $display("FAIL dir%0d_out%0d: got %h@%0d want %h@%0d", t, i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
        end
      end
      if (tbl[t][0] == 4 && tbl[t][4] == 0)
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
          n_tests++;
          if (got_q[i] !== ramp_exp[i]) begin
            n_fail++;
            $display("FAIL dir%0d_ramp%0d: got %0d want %0d", t, i, got_q[i], ramp_exp[i]);
          end
        end
      if (tbl[t][4] == 1 && got_q.size() > 0) begin
        n_tests++;
        if (got_q[0] !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL dir%0d_unsigned: got %h want ffff", t, got_q[0]);
        end
      end
      n_tests++;
      if (done_q.size() !== 1 || done_q[0] !== exp_done) begin
        n_fail++;
        $display("FAIL dir%0d_done: got %0d pulses first@%0d want 1@%0d", t, done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, exp_done);
      end
      n_tests++;
      if (busy_mid !== (tbl[t][0] * tbl[t][1] != 0)) begin
        n_fail++;
        $display("FAIL dir%0d_busy: got %b want %b", t, busy_mid, tbl[t][0] * tbl[t][1] != 0);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int rows = $urandom_range(15);
      int cols = $urandom_range(15);
      for (int k = 0; k < 256; k++) frame[k] = DW'($urandom);
      run_frame(rows, cols, 2, 1'b0);
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count: %0dx%0d got %0d outputs want %0d", t, rows, cols, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_out%0d: got %h@%0d want %h@%0d", t, i, got_q[i], got_cyc_q[i], exp_q[i], exp_cyc_q[i]);
        end
      end
      n_tests++;
      if (done_q.size() !== 1 || done_q[0] !== exp_done) begin
        n_fail++;
        $display("FAIL rnd%0d_done: got %0d pulses want 1@%0d", t, done_q.size(), exp_done);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] want [4] = '{16'd16, 16'd14, 16'd8, 16'd6};
    @(negedge clk);
    start = 1'b1; in_row = DIM_W'(4); in_col = DIM_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = DW'(k + 1);
      @(negedge clk);
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({out_valid, busy, done} !== 3'b000 || out_data !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: got valid/busy/done=%b data=%h want 000 0000", {out_valid, busy, done}, out_data);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) frame[k] = DW'(16 - k);
    run_frame(4, 4, 0, 1'b0);
    n_tests++;
    if (got_q.size() !== 4 || done_q.size() !== 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d outputs %0d done want 4 1", got_q.size(), done_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL midreset_out%0d: got %0d want %0d", i, got_q[i], want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
